// File: rtl/rx_word_loader.sv
// rx_word_loader: parses UART load frames (CMD, N, 4*N data bytes, checksum)
// and writes little-endian 32-bit words into instruction memory.
module rx_word_loader #(
  parameter int unsigned ADDR_W      = 8,
  parameter logic [7:0]  CMD_LOAD    = 8'h4C,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_done_tick,
  input  logic [7:0]        rx_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err
);

  localparam int unsigned TW   = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, COUNT, DATA, CHECK} state_t;

  state_t            state_q, state_d;
  logic [7:0]        words_left_q, words_left_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [7:0]        chk_q, chk_d;
  logic [23:0]       word_q, word_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              mem_we_d, load_busy_d, load_done_d, load_err_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [31:0]       mem_wdata_d;

  // Register every piece of state; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      words_left_q <= '0;
      addr_q       <= '0;
      byte_idx_q   <= '0;
      chk_q        <= '0;
      word_q       <= '0;
      timer_q      <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      load_busy    <= 1'b0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      addr_q       <= addr_d;
      byte_idx_q   <= byte_idx_d;
      chk_q        <= chk_d;
      word_q       <= word_d;
      timer_q      <= timer_d;
      mem_we       <= mem_we_d;
      mem_addr     <= mem_addr_d;
      mem_wdata    <= mem_wdata_d;
      load_busy    <= load_busy_d;
      load_done    <= load_done_d;
      load_err     <= load_err_d;
    end
  end

  // Next-state and output decode; a byte always beats the timeout in the same cycle.
  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    addr_d       = addr_q;
    byte_idx_d   = byte_idx_q;
    chk_d        = chk_q;
    word_d       = word_q;
    timer_d      = timer_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    load_done_d  = 1'b0;
    load_err_d   = load_err;

    if (state_q == IDLE) begin
      timer_d = '0;
      if (rx_done_tick && (rx_data == CMD_LOAD)) begin
        load_err_d = 1'b0;
        state_d    = COUNT;
      end
    end else if (rx_done_tick) begin
      timer_d = '0;
      case (state_q)
        COUNT: begin
          if (rx_data == 8'd0) begin
            load_err_d = 1'b1;
            state_d    = IDLE;
          end else begin
            words_left_d = rx_data;
            addr_d       = '0;
            byte_idx_d   = 2'd0;
            chk_d        = 8'd0;
            state_d      = DATA;
          end
        end
        DATA: begin
          chk_d      = chk_q ^ rx_data;
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: word_d[7:0]   = rx_data;
            2'd1: word_d[15:8]  = rx_data;
            2'd2: word_d[23:16] = rx_data;
            default: begin
              mem_we_d     = 1'b1;
              mem_addr_d   = addr_q;
              mem_wdata_d  = {rx_data, word_q};
              addr_d       = addr_q + ADDR_W'(1);
              words_left_d = words_left_q - 8'd1;
              if (words_left_q == 8'd1) state_d = CHECK;
            end
          endcase
        end
        CHECK: begin
          if (rx_data == chk_q) load_done_d = 1'b1;
          else                  load_err_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (timer_q == TMAX) begin
      load_err_d = 1'b1;
      timer_d    = '0;
      state_d    = IDLE;
    end else begin
      timer_d = timer_q + TW'(1);
    end

    load_busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_rx_word_loader.sv
// Testbench for rx_word_loader: directed frames plus randomized frames checked
// against a frame-level reference model (words, addresses, checksum outcome).
module tb_rx_word_loader;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned TOUT   = 50;
  localparam logic [7:0]  CMD    = 8'h4C;

  logic              clk = 1'b0;
  logic              rst;
  logic              rx_done_tick;
  logic [7:0]        rx_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              load_busy;
  logic              load_done;
  logic              load_err;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];

  rx_word_loader #(.ADDR_W(ADDR_W), .CMD_LOAD(CMD), .TIMEOUT_CYC(TOUT)) dut (
    .clk(clk), .rst(rst), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .load_busy(load_busy), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Record writes and done pulses; a write and a done must never coincide.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        obs_addr.push_back(32'(mem_addr));
        obs_data.push_back(mem_wdata);
      end
      if (load_done) done_cnt++;
      if (mem_we || load_done) chk_eq("we_done_exclusive", 32'(mem_we && load_done), 32'd0);
    end
  end

  task automatic clear_obs();
    obs_addr.delete();
    obs_data.delete();
    done_cnt = 0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rx_data      = b;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
    rx_data      = $urandom();
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_r(input logic [7:0] b);
    send(b, int'($urandom_range(0, 3)));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: random frame of n words; writes land at i mod 2^ADDR_W.
  task automatic run_frame(input string tag, input int n, input bit bad, input int gap);
    logic [31:0] exp_w[$];
    logic [7:0]  d, x;
    logic [31:0] w;
    clear_obs();
    send(CMD, gap);
    send(8'(n), gap);
    x = 8'd0;
    for (int i = 0; i < n; i++) begin
      w = 32'd0;
      for (int k = 0; k < 4; k++) begin
        d = 8'($urandom());
        w = w | (32'(d) << (8 * k));
        x = x ^ d;
        send(d, gap);
      end
      exp_w.push_back(w);
    end
    send(bad ? (x ^ 8'($urandom_range(1, 255))) : x, gap);
    idle(3);
    chk_eq({tag, "_nwrites"}, 32'(obs_data.size()), 32'(n));
    for (int i = 0; i < n && i < obs_data.size(); i++) begin
      chk_eq({tag, "_addr"}, obs_addr[i], 32'(i % (1 << ADDR_W)));
      chk_eq({tag, "_wdata"}, obs_data[i], exp_w[i]);
    end
    chk_eq({tag, "_done"}, 32'(done_cnt), bad ? 32'd0 : 32'd1);
    chk_eq({tag, "_err"}, 32'(load_err), 32'(bad));
    chk_eq({tag, "_busy"}, 32'(load_busy), 32'd0);
    chk_eq({tag, "_hold_addr"}, 32'(mem_addr), 32'((n - 1) % (1 << ADDR_W)));
    chk_eq({tag, "_hold_wdata"}, mem_wdata, exp_w[n-1]);
  endtask

  initial begin
    rst = 1'b1;
    rx_done_tick = 1'b0;
    rx_data = 8'h00;
    idle(3);
    chk_eq("rst_outs", {25'd0, mem_we, 3'd0, load_busy, load_done, load_err}, 32'd0);
    chk_eq("rst_addr", 32'(mem_addr), 32'd0);
    chk_eq("rst_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    idle(2);

    // Single word frame with exact bytes.
    clear_obs();
    send_r(8'h4C); send_r(8'h01); send_r(8'h78); send_r(8'h56); send_r(8'h34); send_r(8'h12);
    send_r(8'h08);
    idle(3);
    chk_eq("one_nwrites", 32'(obs_data.size()), 32'd1);
    if (obs_data.size() > 0) begin
      chk_eq("one_addr", obs_addr[0], 32'd0);
      chk_eq("one_wdata", obs_data[0], 32'h12345678);
    end
    chk_eq("one_done", 32'(done_cnt), 32'd1);
    chk_eq("one_err", 32'(load_err), 32'd0);

    // Two word frame, checksum 44.
    clear_obs();
    send(8'h4C, 0); send(8'h02, 0);
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0); send(8'hDD, 0);
    send(8'h44, 0);
    idle(3);
    chk_eq("two_nwrites", 32'(obs_data.size()), 32'd2);
    if (obs_data.size() > 1) begin
      chk_eq("two_addr1", obs_addr[1], 32'd1);
      chk_eq("two_wdata0", obs_data[0], 32'h44332211);
      chk_eq("two_wdata1", obs_data[1], 32'hDDCCBBAA);
    end
    chk_eq("two_done", 32'(done_cnt), 32'd1);

    // Bad checksum: write stays, error sticks until next command byte.
    clear_obs();
    send_r(8'h4C); send_r(8'h01); send_r(8'h78); send_r(8'h56); send_r(8'h34); send_r(8'h12);
    send_r(8'h00);
    idle(3);
    chk_eq("badck_nwrites", 32'(obs_data.size()), 32'd1);
    chk_eq("badck_done", 32'(done_cnt), 32'd0);
    chk_eq("badck_err", 32'(load_err), 32'd1);
    idle(5);
    chk_eq("badck_err_sticky", 32'(load_err), 32'd1);
    send(8'h4C, 1);
    chk_eq("badck_err_cleared", 32'(load_err), 32'd0);
    chk_eq("badck_busy", 32'(load_busy), 32'd1);
    send(8'h01, 1); send(8'h01, 1); send(8'h02, 1); send(8'h03, 1); send(8'h04, 1);
    send(8'h04, 1);
    idle(3);
    chk_eq("badck_recover_done", 32'(done_cnt), 32'd1);
    chk_eq("badck_recover_wdata", mem_wdata, 32'h04030201);

    // Zero word count.
    clear_obs();
    send(8'h4C, 1); send(8'h00, 1);
    idle(2);
    chk_eq("n0_err", 32'(load_err), 32'd1);
    chk_eq("n0_busy", 32'(load_busy), 32'd0);
    chk_eq("n0_nwrites", 32'(obs_data.size()), 32'd0);

    // Timeout mid-word.
    clear_obs();
    send(8'h4C, 0); send(8'h01, 0); send(8'h78, 0);
    idle(60);
    chk_eq("tout_err", 32'(load_err), 32'd1);
    chk_eq("tout_busy", 32'(load_busy), 32'd0);
    chk_eq("tout_nwrites", 32'(obs_data.size()), 32'd0);

    // Stray byte ignored in IDLE; command byte inside frame is plain data.
    clear_obs();
    send(8'h55, 2);
    chk_eq("stray_busy", 32'(load_busy), 32'd0);
    send(8'h4C, 1); send(8'h01, 1);
    send(8'h4C, 1); send(8'h11, 1); send(8'h22, 1); send(8'h33, 1);
    send(8'h4C ^ 8'h11 ^ 8'h22 ^ 8'h33, 1);
    idle(3);
    chk_eq("cmd_as_data_wdata", mem_wdata, 32'h3322114C);
    chk_eq("cmd_as_data_done", 32'(done_cnt), 32'd1);

    // Reset mid-DATA, one byte short of a write.
    clear_obs();
    send(8'h4C, 1); send(8'h02, 1); send(8'h11, 1); send(8'h22, 1); send(8'h33, 1);
    rst = 1'b1;
    idle(2);
    chk_eq("midrst_outs", {25'd0, mem_we, 3'd0, load_busy, load_done, load_err}, 32'd0);
    chk_eq("midrst_addr", 32'(mem_addr), 32'd0);
    chk_eq("midrst_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    send(8'h44, 3);
    chk_eq("midrst_nwrites", 32'(obs_data.size()), 32'd0);
    chk_eq("midrst_busy", 32'(load_busy), 32'd0);

    // Randomized frames, including address wrap and near-timeout gaps.
    run_frame("rnd_wrap", 10, 1'b0, 0);
    run_frame("rnd_bad", 3, 1'b1, 1);
    run_frame("rnd_slow", 2, 1'b0, 45);
    for (int t = 0; t < 6; t++)
      run_frame("rnd_loop", int'($urandom_range(1, 12)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_word_loader.md
RX_WORD_LOADER -- requirements
Module: rx_word_loader

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 8, as the memory address width.
REQ-002 The block SHALL take parameter CMD_LOAD, default 8'h4C, as the byte that opens a load frame.
REQ-003 The block SHALL take parameter TIMEOUT_CYC, default 100000, as the maximum number of clk cycles allowed between bytes inside a frame.
REQ-004 The block SHALL use clock clk, input, 1 bit; all state updates on its rising edge.
REQ-005 The block SHALL use reset rst, input, 1 bit, asynchronous, active-high.
REQ-006 rx_done_tick  input  1  one-cycle strobe; rx_data is valid in this cycle.
REQ-007 rx_data  input  8  received byte from the UART receiver.
REQ-008 mem_we  output  1  one-cycle instruction-memory write strobe.
REQ-009 mem_addr  output  ADDR_W  word address for the write.
REQ-010 mem_wdata  output  32  word to write.
REQ-011 load_busy  output  1  high whenever the FSM is not in IDLE.
REQ-012 load_done  output  1  one-cycle pulse on a good frame.
REQ-013 load_err  output  1  sticky error flag.

Function
REQ-014 Frame format SHALL be: CMD_LOAD, then N (word count, 8 bits), then 4*N data bytes, then 1 checksum byte.
REQ-015 The FSM SHALL have four states: IDLE, COUNT, DATA and CHECK; bytes are consumed only in cycles where rx_done_tick=1.
REQ-016 IDLE: a byte equal to CMD_LOAD SHALL clear load_err and move to COUNT; any other byte SHALL be ignored.
REQ-017 COUNT: N=0 SHALL set load_err and return to IDLE.
REQ-018 COUNT: N>0 SHALL load words_left=N, set addr=0, byte_idx=0 and chk=0, then move to DATA.
REQ-019 DATA: each byte SHALL be placed little-endian, byte_idx 0 into bits 7:0 through byte_idx 3 into bits 31:24, and SHALL be XORed into chk.
REQ-020 DATA: on byte_idx=3 the block SHALL assert mem_we for exactly one cycle, in the cycle after the edge that sampled that byte, with mem_addr=addr and mem_wdata equal to the complete word.
REQ-021 On each write, addr SHALL increment and words_left SHALL decrement; when words_left reaches 0 the FSM SHALL move to CHECK.
REQ-022 byte_idx SHALL wrap from 3 to 0.
REQ-023 addr SHALL wrap modulo 2^ADDR_W.
REQ-024 CHECK: a byte equal to chk SHALL pulse load_done one cycle after it is sampled; any other value SHALL set load_err. Both cases SHALL return to IDLE.
REQ-025 Timeout: in COUNT, DATA or CHECK, a cycle counter SHALL clear on each rx_done_tick and increment otherwise; reaching TIMEOUT_CYC-1 SHALL set load_err and return to IDLE without a write.
REQ-026 Words already written before a timeout or checksum error SHALL NOT be rolled back.
REQ-027 While busy, a byte equal to CMD_LOAD SHALL be treated as data; it SHALL NOT restart the frame.
REQ-028 mem_we and load_done SHALL never be high in the same cycle.
REQ-029 mem_addr and mem_wdata SHALL hold their last values when mem_we=0.
REQ-030 load_err SHALL stay high until the next CMD_LOAD is accepted in IDLE or a reset occurs.

Reset
REQ-031 rst SHALL force: state IDLE, mem_we=0, mem_addr=0, mem_wdata=0, load_busy=0, load_done=0, load_err=0, and all counters and chk to 0.
REQ-032 Reset mid-frame SHALL abandon the frame immediately; no pending write SHALL be issued after rst deasserts.

Verification
REQ-033 Bytes 4C,01,78,56,34,12,08 -> one mem_we with addr=0 and wdata=32'h12345678, then a load_done pulse, load_err=0.
REQ-034 Frame with N=2, data 11 22 33 44 AA BB CC DD, correct checksum -> writes addr0=44332211 and addr1=DDCCBBAA, then load_done.
REQ-035 Same as REQ-033 but checksum 00 -> the write still occurs, load_err=1, no load_done; a later 4C clears load_err.
REQ-036 Bytes 4C,00 -> load_err=1, FSM back in IDLE, no mem_we.
REQ-037 With TIMEOUT_CYC=50, send 4C,01,78 then idle 60 cycles -> load_err=1, load_busy=0, no mem_we.
REQ-038 Bytes 55,4C inside a frame, and rst asserted mid-DATA -> 55 is ignored in IDLE, 4C is taken as data, and after reset all outputs are 0 with no write.
